// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: RV32I opcodes, MUL/DIV FSM states and
// register-usage helpers used by the hazard and forwarding units.
package rv_pipe_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic {
        IDLE,
        MD_BUSY
    } md_state_e;

    // Only U-type and JAL have no rs1 field.
    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R || op == OP_S || op == OP_B);
    endfunction

endpackage

// File: rtl/hazard_unit_md.sv
// MUL/DIV occupancy tracker: holds EX frozen for MD_LATENCY-1 cycles.
// In: clk, rst, md_start_ex. Out: freeze, md_done, busy.
module md_stall_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start_ex,
    output logic freeze,
    output logic md_done,
    output logic busy
);

    localparam int CW = $clog2(MD_LATENCY);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_LATENCY - 1);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        freeze  = 1'b0;
        md_done = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (md_start_ex) begin
                    freeze  = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                busy = 1'b1;
                // md_start_ex is a don't-care here: EX still holds the op.
                if (cnt_q != CNT_LAST) begin
                    freeze = 1'b1;
                    cnt_d  = cnt_q + CNT_ONE;
                end else begin
                    md_done = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase
        // Reset aborts any sequence without a completion pulse.
        if (rst) begin
            freeze  = 1'b0;
            md_done = 1'b0;
            busy    = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline interlock: load-use stall, redirect flush, MUL/DIV freeze,
// plus saturating stall/flush counters. Outputs are combinational.
module hazard_unit
    import rv_pipe_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [6:0]       opcode_id,
    input  logic [4:0]       rd_ex,
    input  logic             MemRead_ex,
    input  logic             branch_taken_ex,
    input  logic             jump_ex,
    input  logic             md_start_ex,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             md_done,
    output logic             load_use,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             freeze;
    logic             hit;
    logic             redirect;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    md_stall_ctrl #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md (
        .clk         (clk),
        .rst         (rst),
        .md_start_ex (md_start_ex),
        .freeze      (freeze),
        .md_done     (md_done),
        .busy        (busy)
    );

    // Store data (rs2 of S-type) also needs the stall: no MEM->MEM path.
    assign hit = MemRead_ex && (rd_ex != 5'd0) &&
                 ((uses_rs1(opcode_id) && rd_ex == rs1_id) ||
                  (uses_rs2(opcode_id) && rd_ex == rs2_id));

    assign redirect = branch_taken_ex || jump_ex;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        load_use     = 1'b0;
        if (!rst) begin
            if (freeze) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
            end else if (redirect) begin
                // Younger ID instruction is squashed, so no load-use.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (hit) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                load_use    = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (ifid_flush && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (MD_LATENCY=4, CNT_W=4).
// Directed scenarios plus randomized traffic against a cycle model.
module tb_hazard_unit;

    localparam int LAT  = 4;
    localparam int MAXC = 15;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       r;
        logic [6:0] op;
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       jp;
        logic       md;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic [6:0] opcode_id = OP_I;
    logic       MemRead_ex = 1'b0, branch_taken_ex = 1'b0;
    logic       jump_ex = 1'b0, md_start_ex = 1'b0;
    logic       pc_write, ifid_write, ifid_flush, idex_write;
    logic       idex_bubble, exmem_bubble, md_done, load_use, busy;
    logic [3:0] stall_cnt, flush_cnt;
    logic [16:0] obs;

    int n_checks = 0;
    int n_err    = 0;
    int md_left  = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    hazard_unit #(
        .MD_LATENCY (LAT),
        .CNT_W      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .opcode_id       (opcode_id),
        .rd_ex           (rd_ex),
        .MemRead_ex      (MemRead_ex),
        .branch_taken_ex (branch_taken_ex),
        .jump_ex         (jump_ex),
        .md_start_ex     (md_start_ex),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_write      (idex_write),
        .idex_bubble     (idex_bubble),
        .exmem_bubble    (exmem_bubble),
        .md_done         (md_done),
        .load_use        (load_use),
        .busy            (busy),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    assign obs = {pc_write, ifid_write, ifid_flush, idex_write,
                  idex_bubble, exmem_bubble, md_done, load_use, busy,
                  stall_cnt, flush_cnt};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Model outputs: order pcw,ifw,flush,idw,idb,exb,done,lu,busy.
    function automatic logic [16:0] expected();
        logic       u1, u2, hit, redir, frz, done;
        logic [8:0] o;
        frz   = (md_left == 0) ? md_start_ex : (md_left > 1);
        done  = (md_left == 1);
        u1    = !(opcode_id inside {OP_LUI, OP_AUIPC, OP_JAL});
        u2    = opcode_id inside {OP_R, OP_S, OP_B};
        hit   = MemRead_ex && rd_ex != 5'd0 &&
                ((u1 && rd_ex == rs1_id) || (u2 && rd_ex == rs2_id));
        redir = branch_taken_ex || jump_ex;
        o     = 9'b110100000;
        if (!rst) begin
            if (frz)        o = 9'b000001000;
            else if (redir) o = 9'b111110000;
            else if (hit)   o = 9'b000110010;
            if (done) o[2] = 1'b1;
            o[0] = (md_left > 0);
        end
        return {o, 4'(m_stall), 4'(m_flush)};
    endfunction

    task automatic drive(input stim_t s);
        @(negedge clk);
        rst             = s.r;
        opcode_id       = s.op;
        rs1_id          = s.a;
        rs2_id          = s.b;
        rd_ex           = s.rd;
        MemRead_ex      = s.mr;
        branch_taken_ex = s.br;
        jump_ex         = s.jp;
        md_start_ex     = s.md;
    endtask

    task automatic advance();
        logic [16:0] e;
        @(posedge clk);
        e = expected();
        if (rst) begin
            md_left = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!e[16] && m_stall < MAXC) m_stall++;
            if (e[14] && m_flush < MAXC) m_flush++;
            if (md_left == 0 && md_start_ex) md_left = LAT - 1;
            else if (md_left > 0) md_left--;
        end
    endtask

    task automatic do_reset();
        drive('{1'b1, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        advance();
    endtask

    task automatic test_reset();
        stim_t s[$];
        logic [16:0] e;
        s = '{'{1'b1, OP_R, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1},
              '{1'b1, OP_R, 5'd2, 5'd3, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0},
              '{1'b0, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}};
        do_reset();
        foreach (s[i]) begin
            drive(s[i]);
            #1;
            e = expected();
            n_checks++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset[%0d]: got %b expected %b", i, obs, e);
            end
            advance();
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        logic [16:0] e;
        s = '{'{1'b0, OP_R, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0},
              '{1'b0, OP_R, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0}};
        do_reset();
        foreach (s[i]) begin
            drive(s[i]);
            #1;
            e = expected();
            n_checks++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, obs, e);
            end
            advance();
        end
        #1;
        n_checks++;
        if (stall_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_regs_used();
        stim_t s[$];
        logic [16:0] e;
        s = '{'{1'b0, OP_R,     5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0},
              '{1'b0, OP_LUI,   5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0},
              '{1'b0, OP_AUIPC, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0},
              '{1'b0, OP_JAL,   5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0},
              '{1'b0, OP_I,     5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0},
              '{1'b0, OP_LOAD,  5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0},
              '{1'b0, OP_S,     5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0},
              '{1'b0, OP_B,     5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0},
              '{1'b0, OP_JALR,  5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0},
              '{1'b0, OP_I,     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}};
        do_reset();
        foreach (s[i]) begin
            drive(s[i]);
            #1;
            e = expected();
            n_checks++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL regs_used[%0d]: got %b expected %b", i, obs, e);
            end
            advance();
        end
        #1;
        n_checks++;
        if (stall_cnt !== 4'd3) begin
            n_err++;
            $display("FAIL regs_used_cnt: got %0d expected 3", stall_cnt);
        end
    endtask

    task automatic test_redirect();
        stim_t s[$];
        logic [16:0] e;
        s = '{'{1'b0, OP_R, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0},
              '{1'b0, OP_I, 5'd2, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0},
              '{1'b0, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}};
        do_reset();
        foreach (s[i]) begin
            drive(s[i]);
            #1;
            e = expected();
            n_checks++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL redirect[%0d]: got %b expected %b", i, obs, e);
            end
            advance();
        end
        #1;
        n_checks++;
        if (flush_cnt !== 4'd2 || stall_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL redirect_cnt: got flush %0d stall %0d expected 2 0",
                     flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_md(input int n_ops);
        logic [16:0] e;
        stim_t       s;
        do_reset();
        for (int i = 0; i <= n_ops * LAT; i++) begin
            s = '{1'b0, OP_R, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0,
                  (i < n_ops * LAT)};
            drive(s);
            #1;
            e = expected();
            n_checks++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL md_x%0d[%0d]: got %b expected %b",
                         n_ops, i, obs, e);
            end
            advance();
        end
        #1;
        n_checks++;
        if (stall_cnt !== 4'(3 * n_ops) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL md_x%0d_cnt: got stall %0d busy %b expected %0d 0",
                     n_ops, stall_cnt, busy, 3 * n_ops);
        end
    endtask

    task automatic test_reset_mid_md();
        stim_t s[$];
        logic [16:0] e;
        s = '{'{1'b0, OP_R, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1},
              '{1'b0, OP_R, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1},
              '{1'b1, OP_R, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1},
              '{1'b0, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0},
              '{1'b0, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}};
        do_reset();
        foreach (s[i]) begin
            drive(s[i]);
            #1;
            e = expected();
            n_checks++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset_mid_md[%0d]: got %b expected %b",
                         i, obs, e);
            end
            if (i == 3) begin
                n_checks++;
                if (busy !== 1'b0 || md_done !== 1'b0 || stall_cnt !== 4'd0) begin
                    n_err++;
                    $display("FAIL reset_mid_md_idle: got busy %b done %b stall %0d expected 0 0 0",
                             busy, md_done, stall_cnt);
                end
            end
            advance();
        end
    endtask

    task automatic test_saturation();
        logic [16:0] e;
        stim_t       s;
        do_reset();
        for (int i = 0; i < 36; i++) begin
            if (i < 17)
                s = '{1'b0, OP_R, 5'd4, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0};
            else if (i < 35)
                s = '{1'b0, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
            else
                s = '{1'b0, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
            drive(s);
            #1;
            e = expected();
            n_checks++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL saturation[%0d]: got %b expected %b", i, obs, e);
            end
            advance();
        end
        #1;
        n_checks++;
        if (stall_cnt !== 4'd15 || flush_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL saturation_cnt: got stall %0d flush %0d expected 15 15",
                     stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_random(input int n);
        logic [6:0]  ops [10];
        logic [16:0] e;
        stim_t       s;
        ops = '{OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_JAL, OP_JALR,
                OP_LUI, OP_AUIPC, 7'b1110011};
        do_reset();
        for (int i = 0; i < n; i++) begin
            s.r  = ($urandom_range(0, 59) == 0);
            s.op = ops[$urandom_range(0, 9)];
            s.a  = 5'($urandom_range(0, 3));
            s.b  = 5'($urandom_range(0, 3));
            s.rd = 5'($urandom_range(0, 3));
            s.mr = 1'($urandom_range(0, 1));
            s.br = ($urandom_range(0, 7) == 0);
            s.jp = ($urandom_range(0, 9) == 0);
            s.md = (md_left > 0) ? ($urandom_range(0, 7) != 0)
                                 : ($urandom_range(0, 9) == 0);
            drive(s);
            #1;
            e = expected();
            n_checks++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL random[%0d]: got %b expected %b", i, obs, e);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_regs_used();
        test_redirect();
        test_md(1);
        test_md(2);
        test_reset_mid_md();
        test_saturation();
        test_random(600);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
